// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding single bytes from NREQ requesters to one UART transmitter
// Adds an enforced idle gap between frames and a watchdog on tx_done.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int DBIT          = 8,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_tick,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBIT-1:0]    req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_din,
  input  logic                    tx_done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT_TICKS + 2);
  localparam int CW = $clog2(GAP_TICKS + 2);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [DBIT-1:0]   tx_din_q, tx_din_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q, busy_d;
  logic              err_timeout_q, err_timeout_d;
  logic [TW-1:0]     wd_cnt_q, wd_cnt_d;
  logic [CW-1:0]     gap_cnt_q, gap_cnt_d;

  logic              found;
  logic [GW-1:0]     win;
  logic              timeout;

  // First valid requester after last_grant, wrapping around.
  always_comb begin : rr_search
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant_q) + off) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  assign timeout = s_tick && (wd_cnt_q == TW'(TIMEOUT_TICKS - 1));

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    tx_din_d      = tx_din_q;
    wd_cnt_d      = wd_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    req_ready_d   = '0;
    tx_start_d    = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d          = START;
          grant_id_d       = win;
          tx_din_d         = req_data[win*DBIT +: DBIT];
          tx_start_d       = 1'b1;
          req_ready_d[win] = 1'b1;
        end
      end
      START: begin
        state_d  = WAIT_DONE;
        wd_cnt_d = '0;
      end
      WAIT_DONE: begin
        if (s_tick) wd_cnt_d = wd_cnt_q + 1'b1;
        // tx_done wins over a coincident watchdog expiry.
        if (tx_done || timeout) begin
          last_grant_d  = grant_id_q;
          err_timeout_d = !tx_done;
          gap_cnt_d     = '0;
          state_d       = (GAP_TICKS > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (s_tick) begin
          if (gap_cnt_q == CW'(GAP_TICKS - 1)) state_d = IDLE;
          else gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= GW'(NREQ - 1);
      grant_id_q    <= '0;
      tx_din_q      <= '0;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      wd_cnt_q      <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      tx_din_q      <= tx_din_d;
      req_ready_q   <= req_ready_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      wd_cnt_q      <= wd_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_din      = tx_din_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;

endmodule
